mem_port_ctrl: RTL and testbench
================================

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
- REQ-001 SHALL expose parameter ADDR_LIMIT, default 256, number of addressable words in Memory.
- REQ-002 SHALL expose parameter CNT_W, default 16, width of the access counters.
- REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
- REQ-004 SHALL have port reset, input, 1, synchronous active-high reset, sampled on rising clk.
- REQ-005 SHALL have port req_valid, input, 1, requester has an access pending.
- REQ-006 SHALL have port req_write, input, 1, 1 = store, 0 = load.
- REQ-007 SHALL have port req_addr, input, 32, word address.
- REQ-008 SHALL have port req_wdata, input, 32, store data.
- REQ-009 SHALL have port req_ready, output, 1, controller accepts a request this cycle.
- REQ-010 SHALL have port resp_valid, output, 1, response available.
- REQ-011 SHALL have port resp_ready, input, 1, requester consumes the response.
- REQ-012 SHALL have port resp_data, output, 32, load data; 0 for stores and errors.
- REQ-013 SHALL have port resp_err, output, 1, address out of range.
- REQ-014 SHALL have port Adress, output, 32, Memory word address.
- REQ-015 SHALL have port WriteData, output, 32, Memory write data.
- REQ-016 SHALL have port MemRead, output, 1, Memory read strobe.
- REQ-017 SHALL have port MemWrite, output, 1, Memory write strobe.
- REQ-018 SHALL have port wen, output, 1, Memory write enable.
- REQ-019 SHALL have port MemData, input, 32, Memory read data, valid the cycle after MemRead.
- REQ-020 SHALL have port rd_count, output, CNT_W, count of completed in-range loads.
- REQ-021 SHALL have port wr_count, output, CNT_W, count of completed in-range stores.

Function
- REQ-022 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
- REQ-023 SHALL drive req_ready=1 only in IDLE; on req_valid&&req_ready, capture addr/wdata/write into internal registers and go to ISSUE.
- REQ-024 In ISSUE with in-range addr (addr < ADDR_LIMIT), a load SHALL drive MemRead=1 and Adress=addr, then go to WAIT.
- REQ-025 In ISSUE with in-range addr, a store SHALL drive MemWrite=1, wen=1, Adress=addr and WriteData=wdata for exactly one cycle, then go to RESP with resp_data=0.
- REQ-026 In WAIT, MemRead SHALL stay 1 and Adress held; MemData SHALL be registered into resp_data at the end of WAIT; next state RESP.
- REQ-027 An out-of-range addr SHALL skip all Memory strobes, go from ISSUE to RESP, and set resp_err=1 and resp_data=0.
- REQ-028 In RESP, resp_valid SHALL be 1; resp_data and resp_err SHALL be held stable until resp_valid&&resp_ready; then the FSM SHALL return to IDLE.
- REQ-029 Latency, accept edge to resp_valid: load = 3 cycles, store = 2 cycles, error = 2 cycles.
- REQ-030 MemRead, MemWrite and wen SHALL never be 1 simultaneously; all three SHALL be 0 outside ISSUE/WAIT.
- REQ-031 Adress and WriteData SHALL be 0 whenever no strobe is asserted.
- REQ-032 rd_count or wr_count SHALL increment by 1 on the RESP handshake of an in-range access and saturate at 2^CNT_W-1; error responses SHALL not count.
- REQ-033 req_valid and all req_* changes outside IDLE SHALL be ignored; no request queueing.

Reset
- REQ-034 While reset=1, the FSM SHALL enter IDLE and drive req_ready=1 from the next cycle.
- REQ-035 Reset SHALL clear resp_valid, resp_err, resp_data, Adress, WriteData, MemRead, MemWrite, wen, rd_count and wr_count to 0.
- REQ-036 Reset asserted in any state, including mid-store in ISSUE, SHALL abort the access; no strobe SHALL be asserted in the cycle after the reset edge.

Verification
- REQ-037 Store then load: store addr=1, data=0x00000008 -> one-cycle MemWrite=wen=1, Adress=1; then load addr=1 -> resp_data=0x00000008 three cycles after accept; rd_count=1, wr_count=1.
- REQ-038 Out of range: load addr=256 -> no MemRead pulse, resp_err=1 and resp_data=0 two cycles after accept; rd_count unchanged.
- REQ-039 Backpressure: load addr=7 with resp_ready=0 for 5 cycles -> resp_valid and resp_data stay stable, req_ready=0 throughout; release -> IDLE next cycle.
- REQ-040 Reset mid-op: reset asserted in ISSUE of a store to addr=16 -> no MemWrite after the reset edge, Memory word 16 unchanged, all outputs 0, req_ready=1.
- REQ-041 Saturation: with CNT_W=2, 5 stores to addr=4 -> wr_count=3.
- REQ-042 Back-to-back: req_valid held high across loads to addr 15 then 16 -> second accept occurs exactly one cycle after the first RESP handshake.

Source files
------------

// File: rtl/mem_port_ctrl.sv
// Single-port memory access controller: accepts one load/store request at a
// time, drives the memory strobes, returns a held response and keeps
// saturating counts of completed in-range loads and stores.
//
// state | meaning
// IDLE  | ready for a new request (req_ready=1)
// ISSUE | first memory cycle: read or write strobe, or range error detected
// WAIT  | load only: read strobe held, memory data registered at end of cycle
// RESP  | response valid, held until resp_ready
module mem_port_ctrl #(
  parameter int ADDR_LIMIT = 256,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             req_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic             resp_err,
  output logic [31:0]      Adress,
  output logic [31:0]      WriteData,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             wen,
  input  logic [31:0]      MemData,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_write;
  logic [31:0]      r_resp_data;
  logic             r_resp_err;
  logic [CNT_W-1:0] r_rd_count;
  logic [CNT_W-1:0] r_wr_count;
  logic             w_in_range;
  logic             w_resp_hs;

  assign w_in_range = (r_addr < 32'(ADDR_LIMIT));
  assign w_resp_hs  = (r_state == RESP) && resp_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and memory-side strobes
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    wen         = 1'b0;
    Adress      = 32'h0;
    WriteData   = 32'h0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        if (!w_in_range) begin
          w_state_nxt = RESP;
        end else if (r_write) begin
          MemWrite    = 1'b1;
          wen         = 1'b1;
          Adress      = r_addr;
          WriteData   = r_wdata;
          w_state_nxt = RESP;
        end else begin
          MemRead     = 1'b1;
          Adress      = r_addr;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        MemRead     = 1'b1;
        Adress      = r_addr;
        w_state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // A reset landing mid-access must not let the memory see the strobe at
    // the reset edge, otherwise an aborted store would still commit.
    if (reset) begin
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      wen       = 1'b0;
      Adress    = 32'h0;
      WriteData = 32'h0;
    end
  end

  // Request capture and response data/error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_write     <= 1'b0;
      r_resp_data <= 32'h0;
      r_resp_err  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_write <= req_write;
          end
        end
        ISSUE: begin
          r_resp_data <= 32'h0;
          r_resp_err  <= !w_in_range;
        end
        WAIT: r_resp_data <= MemData;
        RESP: begin
          if (resp_ready) begin
            r_resp_data <= 32'h0;
            r_resp_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating completion counters, bumped on the response handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if (w_resp_hs && !r_resp_err) begin
      if (r_write) begin
        if (r_wr_count != CNT_MAX) r_wr_count <= r_wr_count + CNT_ONE;
      end else begin
        if (r_rd_count != CNT_MAX) r_rd_count <= r_rd_count + CNT_ONE;
      end
    end
  end

  assign resp_data = r_resp_data;
  assign resp_err  = r_resp_err;
  assign rd_count  = r_rd_count;
  assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Testbench for mem_port_ctrl: a behavioural memory device plus a
// transaction-level reference model (memory contents, expected latency,
// strobe counts and saturating counters).
module tb_mem_port_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;
  logic [31:0] MemData;

  logic        req_ready, resp_valid, resp_err, MemRead, MemWrite, wen;
  logic [31:0] resp_data, Adress, WriteData;
  logic [15:0] rd_count, wr_count;

  logic        s_req_ready, s_resp_valid, s_resp_err, s_MemRead, s_MemWrite, s_wen;
  logic [31:0] s_resp_data, s_Adress, s_WriteData;
  logic [1:0]  s_rd_count, s_wr_count;

  logic        mem_init;
  logic [31:0] dev_mem   [0:255];
  logic [31:0] model_mem [0:255];
  int          model_rd, model_wr, model_rd_s, model_wr_s;
  int          n_checks, n_fail;

  mem_port_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .Adress(Adress), .WriteData(WriteData), .MemRead(MemRead), .MemWrite(MemWrite), .wen(wen),
    .MemData(MemData), .rd_count(rd_count), .wr_count(wr_count)
  );

  // Narrow-counter instance fed identically, used for saturation checks
  mem_port_ctrl #(.ADDR_LIMIT(256), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(s_req_ready), .resp_valid(s_resp_valid), .resp_ready(resp_ready),
    .resp_data(s_resp_data), .resp_err(s_resp_err),
    .Adress(s_Adress), .WriteData(s_WriteData), .MemRead(s_MemRead), .MemWrite(s_MemWrite), .wen(s_wen),
    .MemData(MemData), .rd_count(s_rd_count), .wr_count(s_wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  // Memory device: write on strobe, read data appears the cycle after MemRead
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= init_word(i);
    end else if (MemWrite && wen && Adress < 32'd256) begin
      dev_mem[Adress[7:0]] <= WriteData;
    end
    if (MemRead && Adress < 32'd256) MemData <= dev_mem[Adress[7:0]];
    else                             MemData <= $urandom;
  end

  task automatic test_reset;
    reset      = 1'b1;
    req_valid  = 1'(($urandom_range(0, 1)));
    req_write  = 1'(($urandom_range(0, 1)));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    resp_ready = 1'(($urandom_range(0, 1)));
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    n_checks++; if (resp_data !== 32'h0) begin n_fail++; $display("FAIL rst_resp_data: got %h want 0", resp_data); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
    n_checks++; if ({MemRead, MemWrite, wen} !== 3'b000) begin n_fail++; $display("FAIL rst_strobes: got %b want 000", {MemRead, MemWrite, wen}); end
    n_checks++; if ({Adress, WriteData} !== 64'h0) begin n_fail++; $display("FAIL rst_bus: got %h/%h want 0/0", Adress, WriteData); end
    n_checks++; if ({rd_count, wr_count} !== 32'h0) begin n_fail++; $display("FAIL rst_counts: got %0d/%0d want 0/0", rd_count, wr_count); end
    reset      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    model_rd = 0; model_wr = 0; model_rd_s = 0; model_wr_s = 0;
    @(negedge clk);
  endtask

  // One complete transaction; starts and ends on a falling edge with the DUT idle
  task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int stall, input bit hold, input logic [31:0] nxt_addr);
    bit          in_rng;
    int          exp_lat, exp_rd, exp_wr, lat, nrd, nwr, bad_bus, unstable;
    logic [31:0] exp_data, held_data;
    logic        held_err;
    in_rng   = (addr < 32'd256);
    exp_lat  = (!wr && in_rng) ? 3 : 2;
    exp_rd   = (!wr && in_rng) ? 2 : 0;
    exp_wr   = (wr && in_rng) ? 1 : 0;
    exp_data = (!wr && in_rng) ? model_mem[addr[7:0]] : 32'h0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready a=%h: got %b want 1", addr, req_ready); end
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = 1'b0;
    lat = 0; nrd = 0; nwr = 0; bad_bus = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (MemRead === 1'b1) begin
        nrd++;
        if (Adress !== addr || MemWrite !== 1'b0 || wen !== 1'b0) bad_bus++;
      end
      if (MemWrite === 1'b1) begin
        nwr++;
        if (Adress !== addr || WriteData !== wdata || wen !== 1'b1 || MemRead !== 1'b0) bad_bus++;
      end
      if (MemRead !== 1'b1 && MemWrite !== 1'b1 && (Adress !== 32'h0 || WriteData !== 32'h0 || wen !== 1'b0)) bad_bus++;
      if (req_ready !== 1'b0) bad_bus++;
      if ({s_req_ready, s_resp_valid, s_resp_data, s_resp_err, s_Adress, s_WriteData, s_MemRead, s_MemWrite, s_wen} !==
          {req_ready, resp_valid, resp_data, resp_err, Adress, WriteData, MemRead, MemWrite, wen}) bad_bus++;
      if (resp_valid === 1'b1) lat = i;
      if (hold) begin
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = nxt_addr;
      end else begin
        req_valid = 1'(($urandom_range(0, 1)));
        req_write = 1'(($urandom_range(0, 1)));
        req_addr  = $urandom;
        req_wdata = $urandom;
      end
    end
    n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL latency a=%h w=%0b: got %0d want %0d", addr, wr, lat, exp_lat); end
    n_checks++; if (nrd != exp_rd) begin n_fail++; $display("FAIL memread_cycles a=%h: got %0d want %0d", addr, nrd, exp_rd); end
    n_checks++; if (nwr != exp_wr) begin n_fail++; $display("FAIL memwrite_cycles a=%h: got %0d want %0d", addr, nwr, exp_wr); end
    n_checks++; if (bad_bus != 0) begin n_fail++; $display("FAIL bus_rules a=%h: got %0d bad cycles want 0", addr, bad_bus); end
    n_checks++; if (resp_data !== exp_data) begin n_fail++; $display("FAIL resp_data a=%h: got %h want %h", addr, resp_data, exp_data); end
    n_checks++; if (resp_err !== !in_rng) begin n_fail++; $display("FAIL resp_err a=%h: got %b want %b", addr, resp_err, !in_rng); end
    held_data = resp_data;
    held_err  = resp_err;
    unstable  = 0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== held_data || resp_err !== held_err ||
          req_ready !== 1'b0 || MemRead !== 1'b0 || MemWrite !== 1'b0) unstable++;
    end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL resp_hold a=%h: got %0d unstable cycles want 0", addr, unstable); end
    resp_ready = 1'b1;
    if (hold) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = nxt_addr;
    end else begin
      req_valid = 1'b0;
    end
    @(posedge clk);
    if (in_rng) begin
      if (wr) begin
        model_mem[addr[7:0]] = wdata;
        if (model_wr < 65535) model_wr++;
        if (model_wr_s < 3) model_wr_s++;
      end else begin
        if (model_rd < 65535) model_rd++;
        if (model_rd_s < 3) model_rd_s++;
      end
    end
    @(negedge clk);
    resp_ready = 1'b0;
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL post_hs_idle a=%h: got valid=%b ready=%b want 0/1", addr, resp_valid, req_ready); end
    n_checks++; if (rd_count !== 16'(model_rd) || wr_count !== 16'(model_wr)) begin n_fail++; $display("FAIL counts a=%h: got %0d/%0d want %0d/%0d", addr, rd_count, wr_count, model_rd, model_wr); end
    n_checks++; if (s_rd_count !== 2'(model_rd_s) || s_wr_count !== 2'(model_wr_s)) begin n_fail++; $display("FAIL sat_counts a=%h: got %0d/%0d want %0d/%0d", addr, s_rd_count, s_wr_count, model_rd_s, model_wr_s); end
  endtask

  task automatic test_store_load;
    do_access(1'b1, 32'd1, 32'h0000_0008, 0, 1'b0, 32'h0);
    do_access(1'b0, 32'd1, 32'h0, 0, 1'b0, 32'h0);
    n_checks++; if (rd_count !== 16'd1 || wr_count !== 16'd1) begin n_fail++; $display("FAIL store_load_counts: got %0d/%0d want 1/1", rd_count, wr_count); end
  endtask

  task automatic test_out_of_range;
    do_access(1'b0, 32'd256, 32'h0, 0, 1'b0, 32'h0);
    do_access(1'b1, 32'hFFFF_FFF0, 32'hDEAD_BEEF, 1, 1'b0, 32'h0);
    do_access(1'b0, 32'd255, 32'h0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_backpressure;
    do_access(1'b0, 32'd7, 32'h0, 4, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back;
    do_access(1'b0, 32'd15, 32'h0, 0, 1'b1, 32'd16);
    do_access(1'b0, 32'd16, 32'h0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_saturation;
    for (int k = 0; k < 5; k++) do_access(1'b1, 32'd4, $urandom, 0, 1'b0, 32'h0);
    n_checks++; if (s_wr_count !== 2'd3) begin n_fail++; $display("FAIL sat_wr_count: got %0d want 3", s_wr_count); end
  endtask

  task automatic test_random;
    int          sel;
    bit          wr;
    logic [31:0] addr;
    for (int k = 0; k < 40; k++) begin
      wr  = 1'(($urandom_range(0, 1)));
      sel = $urandom_range(0, 9);
      if (sel < 7)       addr = 32'($urandom_range(0, 255));
      else if (sel == 7) addr = 32'd256;
      else if (sel == 8) addr = 32'd255;
      else               addr = $urandom;
      do_access(wr, addr, $urandom, $urandom_range(0, 3), 1'b0, 32'h0);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] d;
    d = model_mem[16] ^ 32'hFFFF_0000;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready0: got %b want 1", req_ready); end
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_addr   = 32'd16;
    req_wdata  = d;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (MemWrite !== 1'b1) begin n_fail++; $display("FAIL midrst_in_issue: got MemWrite=%b want 1", MemWrite); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (dev_mem[16] !== model_mem[16]) begin n_fail++; $display("FAIL midrst_mem16: got %h want %h", dev_mem[16], model_mem[16]); end
    n_checks++; if ({MemRead, MemWrite, wen, Adress, WriteData} !== 67'h0) begin n_fail++; $display("FAIL midrst_bus: got %b%b%b %h %h want all 0", MemRead, MemWrite, wen, Adress, WriteData); end
    n_checks++; if ({resp_valid, resp_err, resp_data, rd_count, wr_count} !== 66'h0) begin n_fail++; $display("FAIL midrst_outputs: got v=%b e=%b d=%h rc=%0d wc=%0d want all 0", resp_valid, resp_err, resp_data, rd_count, wr_count); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
    reset = 1'b0;
    model_rd = 0; model_wr = 0; model_rd_s = 0; model_wr_s = 0;
    @(negedge clk);
    n_checks++; if (MemWrite !== 1'b0 || dev_mem[16] !== model_mem[16]) begin n_fail++; $display("FAIL midrst_after: got MemWrite=%b mem16=%h want 0/%h", MemWrite, dev_mem[16], model_mem[16]); end
    do_access(1'b0, 32'd16, 32'h0, 0, 1'b0, 32'h0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    mem_init  = 1'b1;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
    @(negedge clk);
    mem_init = 1'b0;
    test_reset();
    test_store_load();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_random();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
